// File: rtl/data_matrix_pkg.sv
// Shared types and limits for the Data Matrix codeword fetch/decode slice.
// Coordinates are packed {row, col}, eight per codeword, bit7 in the top slot.
package data_matrix_pkg;

  localparam int CW_BITS     = 8;
  localparam int MAX_CW_DEF  = 255;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FETCH = 3'd3,
    ST_EMIT  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] col;
  } coord_t;

  function automatic coord_t coord_at(input logic [127:0] coords, input logic [2:0] slot);
    return coord_t'(coords[{slot, 4'b0000} +: 16]);
  endfunction

  function automatic logic coord_oob(input coord_t c, input logic [7:0] rows, input logic [7:0] cols);
    return (c.row >= rows) || (c.col >= cols);
  endfunction

endpackage

// File: rtl/dm_bit_fetch.sv
// Issues the eight module reads of one codeword and shifts the returned bits in MSB first.
// Out-of-symbol coordinates issue no read and contribute a forced 0 bit.
module dm_bit_fetch
  import data_matrix_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [127:0]       coords,
  input  logic [7:0]         rows,
  input  logic [7:0]         cols,
  input  logic               rd_data,
  output logic               rd_en,
  output logic [7:0]         rd_row,
  output logic [7:0]         rd_col,
  output logic [CW_BITS-1:0] word,
  output logic               word_valid,
  output logic               oob
);

  logic [111:0]       coord_sh_r;
  logic [2:0]         issue_left_r;
  logic               rd_en_r;
  logic [7:0]         rd_row_r;
  logic [7:0]         rd_col_r;
  logic               slot_act_r;
  logic               slot_oob_r;
  logic               samp_act_r;
  logic               samp_oob_r;
  logic [CW_BITS-2:0] word_r;
  logic [2:0]         bit_cnt_r;
  coord_t             cur_s;
  logic               issue_s;
  logic               bit_s;

  // Pick the coordinate issued this cycle: bit7 straight from the load, later slots from the shifter.
  always_comb begin
    cur_s   = coord_t'(coord_sh_r[111:96]);
    issue_s = 1'b0;
    if (load) begin
      cur_s   = coord_at(coords, 3'd7);
      issue_s = 1'b1;
    end else if (issue_left_r != 3'd0) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
    oob   = issue_s && coord_oob(cur_s, rows, cols);
    bit_s = samp_oob_r ? 1'b0 : rd_data;
  end

  // Read issue, slot tagging aligned to the one-cycle read latency, and bit capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      coord_sh_r   <= 112'd0;
      issue_left_r <= 3'd0;
      rd_en_r      <= 1'b0;
      rd_row_r     <= 8'd0;
      rd_col_r     <= 8'd0;
      slot_act_r   <= 1'b0;
      slot_oob_r   <= 1'b0;
      samp_act_r   <= 1'b0;
      samp_oob_r   <= 1'b0;
      word_r       <= '0;
      bit_cnt_r    <= 3'd0;
    end else begin
      if (load) begin
        coord_sh_r   <= coords[111:0];
        issue_left_r <= 3'd7;
      end else if (issue_left_r != 3'd0) begin
        coord_sh_r   <= {coord_sh_r[95:0], 16'h0000};
        issue_left_r <= issue_left_r - 3'd1;
      end
      rd_en_r    <= issue_s && !oob;
      rd_row_r   <= issue_s ? cur_s.row : 8'd0;
      rd_col_r   <= issue_s ? cur_s.col : 8'd0;
      slot_act_r <= issue_s;
      slot_oob_r <= oob;
      samp_act_r <= slot_act_r;
      samp_oob_r <= slot_oob_r;
      if (samp_act_r) begin
        word_r    <= {word_r[CW_BITS-3:0], bit_s};
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end
    end
  end

  assign rd_en      = rd_en_r;
  assign rd_row     = rd_row_r;
  assign rd_col     = rd_col_r;
  assign word       = {word_r, bit_s};
  assign word_valid = samp_act_r && (bit_cnt_r == 3'd7);

endmodule

// File: rtl/data_matrix_decode_ctrl.sv
// Sequences one Data Matrix symbol: request coordinates, fetch eight module bits,
// and stream each packed codeword downstream with last/done/err reporting.
module data_matrix_decode_ctrl
  import data_matrix_pkg::*;
#(
  parameter int MAX_CW  = MAX_CW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [7:0]   total_rows,
  input  logic [7:0]   total_cols,
  output logic         idx_start,
  input  logic         idx_valid,
  input  logic         idx_finish,
  input  logic [127:0] idx_coords,
  output logic         mat_rd_en,
  output logic [7:0]   mat_rd_row,
  output logic [7:0]   mat_rd_col,
  input  logic         mat_rd_data,
  output logic         cw_valid,
  input  logic         cw_ready,
  output logic [7:0]   cw_data,
  output logic         cw_last,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e               state_r;
  state_e               next_state_s;
  logic [7:0]           rows_r;
  logic [7:0]           cols_r;
  logic [7:0]           count_r;
  logic [TW-1:0]        tmo_r;
  logic                 last_r;
  logic                 idx_start_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 err_r;
  logic                 cw_valid_r;
  logic [CW_BITS-1:0]   cw_data_r;
  logic                 cw_last_r;
  logic                 load_s;
  logic                 hs_s;
  logic                 accept_s;
  logic                 zero_dims_s;
  logic                 fsm_err_s;
  logic                 oob_s;
  logic [CW_BITS-1:0]   word_s;
  logic                 word_valid_s;

  assign zero_dims_s = (total_rows == 8'd0) || (total_cols == 8'd0);
  assign accept_s    = (state_r == ST_IDLE) && start;
  assign hs_s        = cw_valid_r && cw_ready;

  dm_bit_fetch u_fetch (
    .clk        (clk),
    .rst        (rst),
    .load       (load_s),
    .coords     (idx_coords),
    .rows       (rows_r),
    .cols       (cols_r),
    .rd_data    (mat_rd_data),
    .rd_en      (mat_rd_en),
    .rd_row     (mat_rd_row),
    .rd_col     (mat_rd_col),
    .word       (word_s),
    .word_valid (word_valid_s),
    .oob        (oob_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode plus abort conditions detected by the sequencer itself.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    fsm_err_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = zero_dims_s ? ST_DONE : ST_REQ;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_REQ: next_state_s = ST_WAIT;
      ST_WAIT: begin
        if (idx_valid) begin
          next_state_s = ST_FETCH;
          load_s       = 1'b1;
        end else if (idx_finish) begin
          next_state_s = ST_DONE;
        end else if (tmo_r == TW'(TIMEOUT - 1)) begin
          next_state_s = ST_DONE;
          fsm_err_s    = 1'b1;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_FETCH: next_state_s = word_valid_s ? ST_EMIT : ST_FETCH;
      ST_EMIT: begin
        if (!hs_s) begin
          next_state_s = ST_EMIT;
        end else if (last_r) begin
          next_state_s = ST_DONE;
        end else if (count_r == 8'(MAX_CW - 1)) begin
          next_state_s = ST_DONE;
          fsm_err_s    = 1'b1;
        end else begin
          next_state_s = ST_REQ;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Registered outputs, latched symbol context, wait timer and codeword holding register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rows_r      <= 8'd0;
      cols_r      <= 8'd0;
      count_r     <= 8'd0;
      tmo_r       <= '0;
      last_r      <= 1'b0;
      idx_start_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      cw_valid_r  <= 1'b0;
      cw_data_r   <= '0;
      cw_last_r   <= 1'b0;
    end else begin
      idx_start_r <= (next_state_s == ST_REQ);
      busy_r      <= (next_state_s != ST_IDLE);
      done_r      <= (next_state_s == ST_DONE);
      if (state_r == ST_WAIT) begin
        tmo_r <= tmo_r + TW'(1);
      end else begin
        tmo_r <= '0;
      end
      if (accept_s) begin
        rows_r  <= total_rows;
        cols_r  <= total_cols;
        count_r <= 8'd0;
        err_r   <= zero_dims_s;
      end else if (fsm_err_s || oob_s) begin
        err_r <= 1'b1;
      end
      if (load_s) begin
        last_r <= idx_finish;
      end
      if ((state_r == ST_FETCH) && word_valid_s) begin
        cw_valid_r <= 1'b1;
        cw_data_r  <= word_s;
        cw_last_r  <= last_r;
      end else if (hs_s) begin
        cw_valid_r <= 1'b0;
        cw_last_r  <= 1'b0;
        if (count_r != 8'hFF) begin
          count_r <= count_r + 8'd1;
        end
      end
    end
  end

  assign idx_start = idx_start_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign cw_valid  = cw_valid_r;
  assign cw_data   = cw_data_r;
  assign cw_last   = cw_last_r;

endmodule

// File: tb/tb_data_matrix_decode_ctrl.sv
// Self-checking bench for data_matrix_decode_ctrl: stub index generator, stub matrix store,
// and a reference codeword model built directly from the coordinate/bit-packing rules.
module tb_data_matrix_decode_ctrl;

  localparam int TMO = 1024;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   total_rows = 8'd0;
  logic [7:0]   total_cols = 8'd0;
  logic         idx_start;
  logic         idx_valid = 1'b0;
  logic         idx_finish = 1'b0;
  logic [127:0] idx_coords = 128'd0;
  logic         mat_rd_en;
  logic [7:0]   mat_rd_row;
  logic [7:0]   mat_rd_col;
  logic         mat_rd_data = 1'b0;
  logic         cw_valid;
  logic         cw_ready = 1'b0;
  logic [7:0]   cw_data;
  logic         cw_last;
  logic         busy;
  logic         done;
  logic         err;

  int checks = 0;
  int failures = 0;

  logic mat [0:255][0:255];

  // stub behaviour knobs
  int opt_respond = 1, opt_delay = 2, opt_ready_hold = 0;
  int opt_stop_on_rd = 0, opt_busy_start_at = -1, opt_start_in_done = 0;

  // per-symbol observations
  logic [127:0] cw_coords_q[$];
  logic [7:0]   exp_d[$];
  logic [7:0]   got_data[$];
  logic         got_last[$];
  int n_idx_start, n_reads, oob_reads, done_seen, done_iter, idx_start_iter;
  int valid_iter, first_cwv_iter, stable_viol, start_in_emit, max_hold, stopped;

  data_matrix_decode_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .total_rows(total_rows), .total_cols(total_cols),
    .idx_start(idx_start), .idx_valid(idx_valid), .idx_finish(idx_finish), .idx_coords(idx_coords),
    .mat_rd_en(mat_rd_en), .mat_rd_row(mat_rd_row), .mat_rd_col(mat_rd_col), .mat_rd_data(mat_rd_data),
    .cw_valid(cw_valid), .cw_ready(cw_ready), .cw_data(cw_data), .cw_last(cw_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mat_rd_data <= mat_rd_en ? mat[mat_rd_row][mat_rd_col] : 1'b0;

  // Reference: bit i of the codeword is the module at slot i, zero when outside the symbol.
  function automatic logic [7:0] model_cw(input logic [127:0] c, input int r, input int k);
    logic [7:0] w;
    int rr, cc;
    for (int i = 0; i < 8; i++) begin
      rr = int'(c[i*16+8 +: 8]);
      cc = int'(c[i*16 +: 8]);
      w[i] = (rr < r && cc < k) ? mat[rr][cc] : 1'b0;
    end
    return w;
  endfunction

  function automatic logic [127:0] rand_coords(input int r, input int k);
    logic [127:0] v;
    for (int i = 0; i < 8; i++) begin
      v[i*16+8 +: 8] = 8'($urandom_range(0, r - 1));
      v[i*16 +: 8]   = 8'($urandom_range(0, k - 1));
    end
    return v;
  endfunction

  task automatic fill_mat();
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 64; j++)
        mat[i][j] = 1'($urandom_range(0, 1));
  endtask

  task automatic queue_symbol(input int n, input int r, input int k);
    logic [127:0] v;
    cw_coords_q.delete();
    exp_d.delete();
    for (int i = 0; i < n; i++) begin
      v = rand_coords(r, k);
      cw_coords_q.push_back(v);
      exp_d.push_back(model_cw(v, r, k));
    end
  endtask

  // Drives one symbol: pulses start, plays the index stub and downstream sink, records what it sees.
  task automatic run_symbol(input int r, input int k, input int budget);
    int pend, hold;
    logic [7:0] held;
    logic prev_v;
    got_data.delete(); got_last.delete();
    n_idx_start = 0; n_reads = 0; oob_reads = 0; done_seen = 0; done_iter = -1;
    idx_start_iter = -1; valid_iter = -1; first_cwv_iter = -1; stable_viol = 0;
    start_in_emit = 0; max_hold = 0; stopped = 0;
    pend = 0; hold = 0; held = 8'd0; prev_v = 1'b0;
    @(negedge clk);
    total_rows = 8'(r); total_cols = 8'(k); start = 1'b1;
    for (int it = 1; it <= budget; it++) begin
      @(negedge clk);
      start = 1'b0; idx_valid = 1'b0; idx_finish = 1'b0; cw_ready = 1'b0;
      if (mat_rd_en) begin
        n_reads++;
        if (int'(mat_rd_row) >= r || int'(mat_rd_col) >= k) oob_reads++;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0 && cw_coords_q.size() > 0) begin
          idx_valid  = 1'b1;
          idx_coords = cw_coords_q.pop_front();
          idx_finish = (cw_coords_q.size() == 0);
          if (valid_iter < 0) valid_iter = it;
        end
      end
      if (idx_start) begin
        n_idx_start++;
        if (idx_start_iter < 0) idx_start_iter = it;
        if (cw_valid) start_in_emit++;
        if (opt_respond != 0) pend = opt_delay;
      end
      if (cw_valid) begin
        if (!prev_v) begin
          hold = 0; held = cw_data;
          if (first_cwv_iter < 0) first_cwv_iter = it;
        end else if (cw_data !== held) begin
          stable_viol++;
        end
        hold++;
        if (hold > opt_ready_hold) cw_ready = 1'b1;
        if (cw_ready) begin
          got_data.push_back(cw_data);
          got_last.push_back(cw_last);
          if (hold > max_hold) max_hold = hold;
        end
      end
      prev_v = cw_valid;
      if (opt_busy_start_at == it) begin
        start = 1'b1; total_rows = 8'd0;
      end
      if (done) begin
        done_seen = 1; done_iter = it;
        if (opt_start_in_done != 0) start = 1'b1;
        break;
      end
      if (opt_stop_on_rd != 0 && mat_rd_en) begin
        stopped = 1;
        break;
      end
    end
  endtask

  task automatic check_symbol(input string name, input int n, input logic exp_err);
    checks++;
    if (done_seen != 1 || got_data.size() != n) begin
      failures++;
      $display("FAIL %s_count done=%0d got_cw=%0d exp_cw=%0d", name, done_seen, got_data.size(), n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (i >= got_data.size() || got_data[i] !== exp_d[i] || got_last[i] !== (i == n - 1)) begin
        failures++;
        $display("FAIL %s_cw%0d got=%h last=%b exp=%h last=%b", name, i, got_data[i], got_last[i], exp_d[i], (i == n - 1));
      end
    end
    checks++;
    if (err !== exp_err || n_idx_start != n) begin
      failures++;
      $display("FAIL %s_err_req err=%b exp=%b idx_start=%0d exp=%0d", name, err, exp_err, n_idx_start, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({idx_start, mat_rd_en, mat_rd_row, mat_rd_col, cw_valid, cw_data, cw_last, busy, done, err} !== 30'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
               {idx_start, mat_rd_en, mat_rd_row, mat_rd_col, cw_valid, cw_data, cw_last, busy, done, err});
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || idx_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle busy=%b idx_start=%b exp=0/0", busy, idx_start);
    end
  endtask

  task automatic test_basic_85();
    logic [13:0] pat;
    logic [127:0] v;
    pat = 14'b10000101100010;
    for (int c = 0; c < 14; c++) mat[0][c] = pat[13 - c];
    for (int i = 0; i < 8; i++) v[i*16 +: 16] = {8'd0, 8'(7 - i)};
    cw_coords_q.delete(); exp_d.delete();
    cw_coords_q.push_back(v); exp_d.push_back(8'h85);
    opt_delay = 2; opt_ready_hold = 0;
    run_symbol(14, 14, 200);
    check_symbol("basic85", 1, 1'b0);
    checks++;
    if (first_cwv_iter - valid_iter != 10 || n_reads != 8) begin
      failures++;
      $display("FAIL basic85_timing latency=%0d exp=10 reads=%0d exp=8", first_cwv_iter - valid_iter, n_reads);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL basic85_after_done busy=%b done=%b exp=0/0", busy, done);
    end
  endtask

  task automatic test_multi();
    int r, k, n;
    for (int round = 0; round < 3; round++) begin
      fill_mat();
      r = $urandom_range(8, 60); k = $urandom_range(8, 60);
      n = (round == 0) ? 3 : $urandom_range(2, 5);
      queue_symbol(n, r, k);
      opt_delay = $urandom_range(1, 5); opt_ready_hold = $urandom_range(0, 3);
      run_symbol(r, k, 400);
      check_symbol("multi", n, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    fill_mat();
    queue_symbol(2, 20, 20);
    opt_delay = 1; opt_ready_hold = 20;
    run_symbol(20, 20, 300);
    check_symbol("backpressure", 2, 1'b0);
    checks++;
    if (stable_viol != 0 || start_in_emit != 0 || max_hold < 21) begin
      failures++;
      $display("FAIL backpressure_hold viol=%0d idx_start_in_emit=%0d hold=%0d exp=0/0/>=21", stable_viol, start_in_emit, max_hold);
    end
    opt_ready_hold = 0;
  endtask

  task automatic test_oob();
    int s, c;
    fill_mat();
    for (int j = 0; j < 64; j++) mat[14][j] = 1'b1;
    queue_symbol(1, 14, 14);
    s = $urandom_range(0, 7);
    cw_coords_q[0][s*16+8 +: 8] = 8'd14;
    c = int'(cw_coords_q[0][s*16 +: 8]);
    exp_d[0] = model_cw(cw_coords_q[0], 14, 14);
    run_symbol(14, 14, 200);
    check_symbol("oob", 1, 1'b1);
    checks++;
    if (n_reads != 7 || oob_reads != 0 || exp_d[0][s] !== 1'b0) begin
      failures++;
      $display("FAIL oob_reads slot=%0d col=%0d reads=%0d exp=7 oob_reads=%0d exp=0", s, c, n_reads, oob_reads);
    end
  endtask

  task automatic test_timeout();
    int d;
    cw_coords_q.delete(); exp_d.delete();
    opt_respond = 0;
    run_symbol(20, 20, TMO + 100);
    d = done_iter - idx_start_iter;
    checks++;
    if (done_seen != 1 || d < TMO || d > TMO + 2 || err !== 1'b1 || got_data.size() != 0) begin
      failures++;
      $display("FAIL timeout done=%0d wait=%0d exp=%0d..%0d err=%b exp=1 cw=%0d", done_seen, d, TMO, TMO + 2, err, got_data.size());
    end
    opt_respond = 1;
  endtask

  task automatic test_zero_dims();
    for (int v = 0; v < 2; v++) begin
      cw_coords_q.delete(); exp_d.delete();
      if (v == 0) run_symbol(0, $urandom_range(1, 255), 20);
      else run_symbol($urandom_range(1, 255), 0, 20);
      checks++;
      if (done_seen != 1 || n_idx_start != 0 || err !== 1'b1 || got_data.size() != 0) begin
        failures++;
        $display("FAIL zero_dims%0d done=%0d idx_start=%0d err=%b exp=1/0/1", v, done_seen, n_idx_start, err);
      end
    end
  endtask

  task automatic test_reset_mid();
    fill_mat();
    queue_symbol(1, 30, 30);
    opt_stop_on_rd = 1;
    run_symbol(30, 30, 100);
    opt_stop_on_rd = 0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (stopped != 1 || {idx_start, mat_rd_en, mat_rd_row, mat_rd_col, cw_valid, cw_data, cw_last, busy, done, err} !== 30'd0) begin
      failures++;
      $display("FAIL reset_mid stopped=%0d outs=%h exp=0", stopped,
               {idx_start, mat_rd_en, mat_rd_row, mat_rd_col, cw_valid, cw_data, cw_last, busy, done, err});
    end
    rst = 1'b1;
    queue_symbol(2, 25, 40);
    run_symbol(25, 40, 300);
    check_symbol("post_reset", 2, 1'b0);
  endtask

  task automatic test_start_busy();
    fill_mat();
    queue_symbol(2, 33, 17);
    opt_delay = 5; opt_busy_start_at = 4; opt_start_in_done = 1;
    run_symbol(33, 17, 300);
    opt_busy_start_at = -1; opt_start_in_done = 0; opt_delay = 2;
    check_symbol("start_busy", 2, 1'b0);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || idx_start !== 1'b0) begin
      failures++;
      $display("FAIL start_in_done busy=%b idx_start=%b exp=0/0", busy, idx_start);
    end
  endtask

  initial begin
    test_reset();
    test_basic_85();
    test_multi();
    test_back_to_back();
    test_oob();
    test_timeout();
    test_zero_dims();
    test_reset_mid();
    test_start_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
